// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared round-state encoding and timing constants
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_OVER      = 2'd3
  } game_state_e;

  localparam int TIME_W = 6;

  // Shared by score_counter and the display blocks as well
  localparam int DEFAULT_CLK_HZ = 100_000_000;

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-pulse-per-second tick from a free-running cycle count
module sec_tick_gen
  import game_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
  input  logic clkIn,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic sec_tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_q, count_d;

  assign sec_tick = enable && (count_q == LAST);

  // Disabled means frozen, so a paused second resumes where it stopped
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = sec_tick ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - whack-a-mole round sequencer and hit validator
// Optional PAUSE_EN adds a pause_btn input that freezes the PLAY timer and hits.
module game_round_controller
  import game_pkg::*;
#(
  parameter int CLK_HZ            = DEFAULT_CLK_HZ,
  parameter int GAME_SECONDS      = 30,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int NUM_MOLES         = 4
) (
  input  logic                 clkIn,
  input  logic                 reset,
  input  logic                 start_btn,
  input  logic [NUM_MOLES-1:0] mole_sel,
  input  logic                 mole_new,
  input  logic [NUM_MOLES-1:0] hit_btn,
`ifdef PAUSE_EN
  input  logic                 pause_btn,
`endif
  output logic                 gameStart,
  output logic                 game_active,
  output logic                 timer_expired,
  output logic                 player_scored,
  output logic [TIME_W-1:0]    time_left,
  output logic [1:0]           state
);

  localparam logic [TIME_W-1:0] GAME_T  = TIME_W'(GAME_SECONDS);
  localparam logic [TIME_W-1:0] COUNT_T = TIME_W'(COUNTDOWN_SECONDS);

  game_state_e           state_q, state_d;
  logic [TIME_W-1:0]     time_left_q, time_left_d;
  logic                  start_q;
  logic [NUM_MOLES-1:0]  hit_q;
  logic                  hit_lock_q, hit_lock_d;
  logic                  game_start_q, game_start_d;
  logic                  game_active_q, game_active_d;
  logic                  timer_expired_q, timer_expired_d;
  logic                  player_scored_q, player_scored_d;

  logic                  start_rise;
  logic [NUM_MOLES-1:0]  hit_rise;
  logic                  sec_tick;
  logic                  tick_clear;
  logic                  tick_en;
  logic                  final_tick;
  logic                  score_ok;
  logic                  paused;
  logic                  paused_next;

  assign start_rise = start_btn & ~start_q;
  assign hit_rise   = hit_btn & ~hit_q;
  assign tick_en    = ((state_q == ST_COUNTDOWN) || (state_q == ST_PLAY)) && !paused;

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick_gen (
    .clkIn   (clkIn),
    .reset   (reset),
    .clear   (tick_clear),
    .enable  (tick_en),
    .sec_tick(sec_tick)
  );

  always_comb begin
    state_d         = state_q;
    time_left_d     = time_left_q;
    hit_lock_d      = hit_lock_q;
    game_start_d    = 1'b0;
    timer_expired_d = 1'b0;
    player_scored_d = 1'b0;
    final_tick      = 1'b0;
    score_ok        = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d     = ST_COUNTDOWN;
          time_left_d = COUNT_T;
        end
      end
      ST_COUNTDOWN: begin
        if (sec_tick) begin
          if (time_left_q <= TIME_W'(1)) begin
            state_d      = ST_PLAY;
            time_left_d  = GAME_T;
            game_start_d = 1'b1;
          end else begin
            time_left_d = time_left_q - TIME_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (sec_tick) begin
          if (time_left_q <= TIME_W'(1)) begin
            final_tick      = 1'b1;
            state_d         = ST_OVER;
            time_left_d     = '0;
            timer_expired_d = 1'b1;
          end else begin
            time_left_d = time_left_q - TIME_W'(1);
          end
        end
        // A hit racing the final tick or a fresh mole is discarded
        score_ok = (|(hit_rise & mole_sel)) && !hit_lock_q && !mole_new
                   && !final_tick && !paused;
        player_scored_d = score_ok;
        if (mole_new) begin
          hit_lock_d = 1'b0;
        end else if (score_ok) begin
          hit_lock_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != ST_PLAY) begin
      hit_lock_d = 1'b0;
    end
    tick_clear    = (state_d != state_q) &&
                    ((state_d == ST_COUNTDOWN) || (state_d == ST_PLAY));
    game_active_d = (state_d == ST_PLAY) && !paused_next;
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      time_left_q     <= '0;
      start_q         <= 1'b0;
      hit_q           <= '0;
      hit_lock_q      <= 1'b0;
      game_start_q    <= 1'b0;
      game_active_q   <= 1'b0;
      timer_expired_q <= 1'b0;
      player_scored_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      time_left_q     <= time_left_d;
      start_q         <= start_btn;
      hit_q           <= hit_btn;
      hit_lock_q      <= hit_lock_d;
      game_start_q    <= game_start_d;
      game_active_q   <= game_active_d;
      timer_expired_q <= timer_expired_d;
      player_scored_q <= player_scored_d;
    end
  end

`ifdef PAUSE_EN
  logic pause_q;
  logic paused_q, paused_d;

  always_comb begin
    paused_d = paused_q;
    if ((state_q == ST_PLAY) && pause_btn && !pause_q) begin
      paused_d = !paused_q;
    end
    if (state_d != ST_PLAY) begin
      paused_d = 1'b0;
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      pause_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      pause_q  <= pause_btn;
      paused_q <= paused_d;
    end
  end

  assign paused      = paused_q;
  assign paused_next = paused_d;
`else
  assign paused      = 1'b0;
  assign paused_next = 1'b0;
`endif

  assign gameStart     = game_start_q;
  assign game_active   = game_active_q;
  assign timer_expired = timer_expired_q;
  assign player_scored = player_scored_q;
  assign time_left     = time_left_q;
  assign state         = state_q;

endmodule
